// File: rtl/seq_comparator_if.sv
// seq_comparator_if: start/busy/done handshake, operands and result flags of seq_comparator.
// Ports: master drives start, is_signed, a, b; slave drives busy, done, greater, less, equal.
// WIDTH must match the WIDTH of the attached comparator.
interface seq_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             greater;
    logic             less;
    logic             equal;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, greater, less, equal
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, greater, less, equal
    );
endinterface

// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle magnitude compare of WIDTH-bit operands, CHUNK bits per clock, MSB chunk first.
// Latency: start at E0, done at E0+NCHUNK (E0+1..E0+NCHUNK with COMPARATOR_EARLY_EXIT_EN defined).
// Backpressure: start is only accepted in IDLE/DONE; start, a, b, is_signed are ignored while busy.
// Ports: clk, reset (async active-high), cmp (seq_comparator_if.slave: start/is_signed/a/b in,
//        busy/done/greater/less/equal out). Optional macro: COMPARATOR_EARLY_EXIT_EN.
module seq_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         reset,
    seq_comparator_if.slave cmp
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             greater_q;
    logic             less_q;
    logic             equal_q;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             chunk_ne;
    logic             chunk_gt;
    logic             accept;
    logic             finish;
    logic             res_gt;
    logic             res_lt;

`ifndef COMPARATOR_EARLY_EXIT_EN
    // First differing chunk is remembered so later chunks cannot override it.
    logic             decided;
    logic             dec_gt;
`endif

    assign chunk_a  = op_a[int'(idx) * CHUNK +: CHUNK];
    assign chunk_b  = op_b[int'(idx) * CHUNK +: CHUNK];
    assign chunk_ne = (chunk_a != chunk_b);
    assign chunk_gt = (chunk_a > chunk_b);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        res_gt    = 1'b0;
        res_lt    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (cmp.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
`ifdef COMPARATOR_EARLY_EXIT_EN
                finish = chunk_ne || (idx == '0);
                res_gt = chunk_gt;
                res_lt = chunk_ne && !chunk_gt;
`else
                finish = (idx == '0);
                res_gt = decided ? dec_gt  : chunk_gt;
                res_lt = decided ? !dec_gt : (chunk_ne && !chunk_gt);
`endif
                if (finish) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
`ifndef COMPARATOR_EARLY_EXIT_EN
            decided   <= 1'b0;
            dec_gt    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a <= cmp.a ^ (cmp.is_signed ? MSB_MASK : '0);
                op_b <= cmp.b ^ (cmp.is_signed ? MSB_MASK : '0);
                idx  <= LAST_IDX;
            end else if (state == RUN && !finish) begin
                idx <= idx - 1'b1;
            end
`ifndef COMPARATOR_EARLY_EXIT_EN
            if (accept) begin
                decided <= 1'b0;
                dec_gt  <= 1'b0;
            end else if (state == RUN && chunk_ne && !decided) begin
                decided <= 1'b1;
                dec_gt  <= chunk_gt;
            end
`endif
            // Flags change only on the edge that enters DONE.
            if (finish) begin
                greater_q <= res_gt;
                less_q    <= res_lt;
                equal_q   <= !(res_gt || res_lt);
            end
        end
    end

    assign cmp.busy    = (state == RUN);
    assign cmp.done    = (state == DONE);
    assign cmp.greater = greater_q;
    assign cmp.less    = less_q;
    assign cmp.equal   = equal_q;
endmodule

// File: tb/tb_seq_comparator.sv
// tb_seq_comparator: directed vectors for seq_comparator at WIDTH=16, CHUNK=4.
// Outputs are sampled 1 ns after the rising edge; inputs are driven right after sampling.
// Expected latencies follow COMPARATOR_EARLY_EXIT_EN when it is defined for the build.
module tb_seq_comparator;
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;
`ifdef COMPARATOR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic reset;
    int   vectors;
    int   fails;
    logic [2:0] last_gle;

    seq_comparator_if #(.WIDTH(16)) cif ();

    seq_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .cmp   (cif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] flags();
        return {cif.greater, cif.less, cif.equal};
    endfunction

    function automatic int lat(input int early_lat);
        return EARLY ? early_lat : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a compare on the next edge, optionally disturbs the inputs during RUN,
    // and checks handshake, held flags, latency and final flags.
    task automatic run_cmp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic sg, input logic [2:0] exp_gle, input int exp_lat,
                           input bit disturb);
        int n;
        cif.a         = av;
        cif.b         = bv;
        cif.is_signed = sg;
        cif.start     = 1'b1;
        @(posedge clk); #1;
        cif.start = 1'b0;
        check({tag, "_busy_e0"}, {31'b0, cif.busy}, 32'd1);
        check({tag, "_done_e0"}, {31'b0, cif.done}, 32'd0);
        check({tag, "_hold_e0"}, {29'b0, flags()}, {29'b0, last_gle});
        n = 0;
        while (!cif.done && n < 20) begin
            if (disturb && n == 0) begin
                cif.start     = 1'b1;
                cif.a         = 16'hFFFF;
                cif.b         = 16'h0000;
                cif.is_signed = 1'b1;
            end
            @(posedge clk); #1;
            cif.start = 1'b0;
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_flags"}, {29'b0, flags()}, {29'b0, exp_gle});
        check({tag, "_busy_end"}, {31'b0, cif.busy}, 32'd0);
        last_gle = exp_gle;
    endtask

    initial begin
        vectors       = 0;
        fails         = 0;
        last_gle      = 3'b000;
        cif.start     = 1'b0;
        cif.is_signed = 1'b0;
        cif.a         = '0;
        cif.b         = '0;
        reset         = 1'b1;
        #12;
        check("reset_outputs", {27'b0, cif.busy, cif.done, flags()}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {27'b0, cif.busy, cif.done, flags()}, 32'd0);

        run_cmp("uns_less",      16'h0001, 16'h0002, 1'b0, LT, lat(4), 1'b0);
        run_cmp("msb_uns",       16'hA000, 16'h5000, 1'b0, GT, lat(1), 1'b0);
        run_cmp("msb_sgn",       16'hA000, 16'h5000, 1'b1, LT, lat(1), 1'b0);
        run_cmp("equal_uns",     16'h6666, 16'h6666, 1'b0, EQ, lat(4), 1'b0);
        run_cmp("equal_sgn",     16'h6666, 16'h6666, 1'b1, EQ, lat(4), 1'b0);
        // Issued from the DONE cycle of equal_sgn: back-to-back, equal must hold until the new done.
        run_cmp("b2b_greater",   16'h1111, 16'h0000, 1'b0, GT, lat(1), 1'b0);
        run_cmp("ffff_uns",      16'hFFFF, 16'h0000, 1'b0, GT, lat(1), 1'b0);
        run_cmp("ffff_sgn",      16'hFFFF, 16'h0000, 1'b1, LT, lat(1), 1'b0);
        run_cmp("min_max_sgn",   16'h8000, 16'h7FFF, 1'b1, LT, lat(1), 1'b0);
        run_cmp("min_max_uns",   16'h8000, 16'h7FFF, 1'b0, GT, lat(1), 1'b0);
        run_cmp("lsb_diff_gt",   16'h1235, 16'h1234, 1'b0, GT, 4, 1'b0);
        // Start with 0xFFFF/0x0000 signed pulsed during RUN must not alter the result.
        run_cmp("ignore_start",  16'h0001, 16'h0002, 1'b0, LT, lat(4), 1'b1);

        // Let DONE fall back to IDLE, then abort a compare with reset at E0+2.
        @(posedge clk); #1;
        check("idle_after_done", {30'b0, cif.busy, cif.done}, 32'd0);
        cif.a         = 16'h0001;
        cif.b         = 16'h0002;
        cif.is_signed = 1'b0;
        cif.start     = 1'b1;
        @(posedge clk); #1;
        cif.start = 1'b0;
        check("abort_busy_e0", {31'b0, cif.busy}, 32'd1);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_outputs", {27'b0, cif.busy, cif.done, flags()}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", {30'b0, cif.busy, cif.done}, 32'd0);
        end
        last_gle = 3'b000;
        run_cmp("after_reset",   16'h0001, 16'h0002, 1'b0, LT, lat(4), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/seq_comparator.md
# seq_comparator

Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. It processes CHUNK bits per clock, starting at the MSB chunk, and supports unsigned and two's-complement signed modes. A start/busy/done handshake controls it, and the result flags are registered. It succeeds the single-cycle 4-bit combinational comparator wherever wide operands would create a long combinational compare path.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK
- CHUNK, 4, bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH; NCHUNK = WIDTH/CHUNK
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a compare; sampled only when accepting (IDLE or DONE)
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; captured with start
- a  input  WIDTH  operand A; captured with start
- b  input  WIDTH  operand B; captured with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a result is written
- greater  output  1  registered: A > B
- less  output  1  registered: A < B
- equal  output  1  registered: A == B

## Operation
- States are IDLE, RUN and DONE. The state is held in a register; busy = (state == RUN) and done = (state == DONE).
- Start is accepted in IDLE or DONE. On acceptance:
  - Capture a and b into internal registers. If is_signed = 1, invert bit WIDTH-1 of both copies, so an unsigned compare gives the signed order.
  - Set the chunk index to NCHUNK-1 and go to RUN.
- In IDLE or DONE with start = 0, the next state is IDLE.
- In RUN, each edge compares chunk[idx] of A against chunk[idx] of B as unsigned CHUNK-bit values:
  - Chunks differ: write greater/less (one-hot, equal = 0) per the configuration rules below, then go to DONE.
  - Chunks equal and idx == 0: write the final result and go to DONE.
  - Chunks equal and idx > 0: idx decrements.
- Result flags update only on the edge that enters DONE. They hold their value through IDLE and through the next RUN until the next result. After the first result, exactly one flag is high.
- start, a, b and is_signed are ignored while in RUN. Changing inputs after capture has no effect.

## Timing
- Reset (asynchronous, any time, including mid-RUN): state = IDLE, busy = 0, done = 0, greater = less = equal = 0, idx = 0, operand registers = 0. An in-flight compare is aborted and produces no done.
- Start accepted at edge E0 gives busy = 1 from E0.
- The compare of chunk NCHUNK-k happens at edge E0+k.
- The deciding edge Ed sets done = 1 and the flags in the same cycle. done drops at Ed+1 unless a new start is accepted there.
- Back-to-back operation: start held high in the DONE cycle is accepted at Ed+1. Sustained throughput is one result per (latency + 1) cycles.
- Latency (Ed - E0) ranges from 1 to NCHUNK, as set by the configuration below.

## Configuration
- COMPARATOR_EARLY_EXIT_EN defined:
  - RUN ends at the first differing chunk.
  - Latency = number of chunks examined, from 1 (MSB chunk differs) to NCHUNK (differ only in the LSB chunk, or equal).
- COMPARATOR_EARLY_EXIT_EN undefined (default):
  - The first difference is recorded in an internal sticky decided/greater register, and RUN always runs all NCHUNK chunks.
  - Later chunks cannot override a recorded difference.
  - Latency is always NCHUNK, independent of the data.
  - Flags are identical to the defined case.

## Test plan
All cases use WIDTH = 16, CHUNK = 4.
- Unsigned less: a = 0x0001, b = 0x0002, is_signed = 0 → less = 1, greater = equal = 0. done at E0+4 in both configs.
- MSB-chunk difference: a = 0xA000, b = 0x5000.
  - is_signed = 0 → greater = 1.
  - is_signed = 1 → less = 1.
  - Latency is 1 with COMPARATOR_EARLY_EXIT_EN and 4 without it.
- Equal: a = b = 0x6666, either mode → equal = 1 after 4 cycles. Then a = 0x1111, b = 0x0000 back-to-back (start held high in the DONE cycle) → greater = 1, and flags hold equal = 1 until the new done.
- Extremes:
  - 0xFFFF vs 0x0000, unsigned → greater = 1; signed → less = 1.
  - 0x8000 vs 0x7FFF, signed → less = 1; unsigned → greater = 1.
- Protocol and reset:
  - Start pulsed with new operands during RUN is ignored; the result matches the originally captured operands.
  - Reset asserted at E0+2 of a 4-cycle compare → all outputs 0 immediately and no done pulse.
  - A fresh start after reset completes normally.
